// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-requester round-robin burst arbiter.
// State encoding, requester IDs (matching Selector polarity) and sizing helpers.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_BURST = 2'b01
    } arb_state_t;

    typedef enum logic {
        REQ_B = 1'b0,
        REQ_A = 1'b1
    } req_id_t;

    localparam int unsigned LEN_W_DEF   = 3;
    localparam int unsigned TIMEOUT_DEF = 64;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick between requesters A and B.
// On a tie the requester that was not granted last wins.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic    ReqA,
    input  logic    ReqB,
    input  req_id_t LastGnt,
    output req_id_t Win,
    output logic    Any
);

    always_comb begin
        Any = ReqA | ReqB;
        if (ReqA && ReqB) begin
            Win = (LastGnt == REQ_A) ? REQ_B : REQ_A;
        end else if (ReqA) begin
            Win = REQ_A;
        end else begin
            Win = REQ_B;
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin burst arbiter driving the select of a shared 2:1 data mux.
// Optional stall watchdog is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = LEN_W_DEF
`ifdef MUX_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
`endif
)(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             ReqA,
    input  logic             ReqB,
    input  logic [LEN_W-1:0] LenA,
    input  logic [LEN_W-1:0] LenB,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             Ready,
    output logic             Selector,
    output logic [WIDTH-1:0] DataOut,
    output logic             Valid,
    output logic             GntA,
    output logic             GntB,
    output logic             BeatAckA,
    output logic             BeatAckB,
    output logic             DoneA,
    output logic             DoneB,
    output logic             Busy,
    output logic             TimeoutErr
);

    arb_state_t       state_reg, state_next;
    logic [LEN_W-1:0] beat_cnt_reg, beat_cnt_next;
    req_id_t          last_gnt_reg, last_gnt_next;
    req_id_t          selector_reg, selector_next;
    logic             gnt_a_reg, gnt_a_next;
    logic             gnt_b_reg, gnt_b_next;
    logic             valid_reg, valid_next;
    logic             done_a_reg, done_a_next;
    logic             done_b_reg, done_b_next;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned        STALL_W   = cnt_width(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);
    logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic               timeout_err_reg, timeout_err_next;
`endif

    req_id_t          pick_win;
    logic             pick_any;
    logic             req_cur;
    logic [LEN_W-1:0] len_win;
    logic             release_burst;

    rr_pick u_rr_pick (
        .ReqA    (ReqA),
        .ReqB    (ReqB),
        .LastGnt (last_gnt_reg),
        .Win     (pick_win),
        .Any     (pick_any)
    );

    // Only the granted requester's Req/Len are ever looked at during a burst.
    assign req_cur = (selector_reg == REQ_A) ? ReqA : ReqB;
    assign len_win = (pick_win == REQ_A) ? LenA : LenB;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg       <= ARB_IDLE;
            beat_cnt_reg    <= '0;
            last_gnt_reg    <= REQ_B;
            selector_reg    <= REQ_B;
            gnt_a_reg       <= 1'b0;
            gnt_b_reg       <= 1'b0;
            valid_reg       <= 1'b0;
            done_a_reg      <= 1'b0;
            done_b_reg      <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            stall_cnt_reg   <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            beat_cnt_reg    <= beat_cnt_next;
            last_gnt_reg    <= last_gnt_next;
            selector_reg    <= selector_next;
            gnt_a_reg       <= gnt_a_next;
            gnt_b_reg       <= gnt_b_next;
            valid_reg       <= valid_next;
            done_a_reg      <= done_a_next;
            done_b_reg      <= done_b_next;
`ifdef MUX_ARB_TIMEOUT_EN
            stall_cnt_reg   <= stall_cnt_next;
            timeout_err_reg <= timeout_err_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        beat_cnt_next    = beat_cnt_reg;
        last_gnt_next    = last_gnt_reg;
        selector_next    = selector_reg;
        gnt_a_next       = gnt_a_reg;
        gnt_b_next       = gnt_b_reg;
        valid_next       = valid_reg;
        done_a_next      = 1'b0;
        done_b_next      = 1'b0;
        release_burst    = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        timeout_err_next = 1'b0;
`endif

        unique case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_next    = ARB_BURST;
                    beat_cnt_next = len_win;
                    selector_next = pick_win;
                    gnt_a_next    = (pick_win == REQ_A);
                    gnt_b_next    = (pick_win == REQ_B);
                    valid_next    = 1'b1;
                end
            end
            ARB_BURST: begin
                // Abort wins over a beat accepted on the same edge.
                if (!req_cur) begin
                    release_burst = 1'b1;
                end else if (Ready) begin
                    if (beat_cnt_reg == '0) begin
                        release_burst = 1'b1;
                        done_a_next   = (selector_reg == REQ_A);
                        done_b_next   = (selector_reg == REQ_B);
                    end else begin
                        beat_cnt_next = beat_cnt_reg - LEN_W'(1);
                    end
                end
`ifdef MUX_ARB_TIMEOUT_EN
                else if (stall_cnt_reg == STALL_MAX) begin
                    release_burst    = 1'b1;
                    timeout_err_next = 1'b1;
                end
`endif
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        // Selector is deliberately left alone on release.
        if (release_burst) begin
            state_next    = ARB_IDLE;
            gnt_a_next    = 1'b0;
            gnt_b_next    = 1'b0;
            valid_next    = 1'b0;
            last_gnt_next = selector_reg;
        end

`ifdef MUX_ARB_TIMEOUT_EN
        if ((state_reg == ARB_BURST) && (state_next == ARB_BURST) && !Ready) begin
            stall_cnt_next = stall_cnt_reg + STALL_W'(1);
        end else begin
            stall_cnt_next = '0;
        end
`endif
    end

    always_comb begin
        Selector = (selector_reg == REQ_A);
        DataOut  = Selector ? DataA : DataB;
        Valid    = valid_reg;
        GntA     = gnt_a_reg;
        GntB     = gnt_b_reg;
        BeatAckA = gnt_a_reg & Ready;
        BeatAckB = gnt_b_reg & Ready;
        DoneA    = done_a_reg;
        DoneB    = done_b_reg;
        Busy     = (state_reg == ARB_BURST);
`ifdef MUX_ARB_TIMEOUT_EN
        TimeoutErr = timeout_err_reg;
`else
        TimeoutErr = 1'b0;
`endif
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares one downstream datapath port between two requesters (A and B) by driving the select line of the 2:1 data mux in front of that port. Grants whole bursts of 1–8 beats, counts beats against a downstream Ready handshake, and pulses a per-requester Done on completion. It sits between the two bus masters and the shared write/transfer port, and is the only block allowed to drive that mux's Selector.

## Interface
- WIDTH, 32, data width of each requester and of DataOut
- LEN_W, 3, width of burst length fields (beats = Len+1, max 8)
- TIMEOUT, 64, stall cycles before forced release (only with MUX_ARB_TIMEOUT_EN)

- Clk  in  1  single clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- ReqA / ReqB  in  1  request; must be held through the burst
- LenA / LenB  in  LEN_W  beats-1, sampled at grant
- DataA / DataB  in  WIDTH  beat data, valid while granted
- Ready  in  1  downstream accepts the current beat
- Selector  out  1  mux select, 1 = A, 0 = B
- DataOut  out  WIDTH  combinational: Selector ? DataA : DataB
- Valid  out  1  beat on DataOut is valid
- GntA / GntB  out  1  grant, one-hot or both 0
- BeatAckA / BeatAckB  out  1  combinational GntX & Ready: the beat was taken
- DoneA / DoneB  out  1  one-cycle pulse after the last beat of a burst
- Busy  out  1  state is BURST
- TimeoutErr  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE (2'b00) and BURST (2'b01). All outputs except DataOut and BeatAck are registered.
- Reset (async, Rst_n=0): state IDLE; Selector, Valid, GntA, GntB, DoneA, DoneB, Busy, TimeoutErr, BeatCnt and StallCnt are 0; LastGnt=B, so A wins the first tie.
- IDLE, single request: grant that requester.
- IDLE, both requesting: grant the requester not in LastGnt.
- On grant: load BeatCnt from that requester's Len, set Selector and GntX, set Valid=1, and go to BURST.
- BURST beat: each edge with Ready=1 accepts a beat.
  - If BeatCnt=0: go to IDLE, clear Gnt and Valid, pulse DoneX, and set LastGnt=X.
  - Otherwise decrement BeatCnt.
- Abort: GntX=1 and ReqX=0 at an edge → go to IDLE, clear Gnt and Valid, set LastGnt=X, no DoneX. Abort has priority over beat acceptance in the same cycle.
- Selector holds its last value in IDLE and is not cleared on release.
- Req and Len changes from the non-granted requester during BURST are ignored.

## Timing
- Grant latency is 1 cycle: Req high at edge N → Gnt, Valid and Selector valid after edge N.
- Last beat accepted at edge M → Gnt, Valid and Busy are 0 and DoneX is 1 after edge M.
- IDLE arbitrates during the Done cycle, so the next grant is at the earliest after edge M+1. There is always a one-cycle bubble between bursts.
- Throughput for a burst of Len+1 beats with Ready held high: Len+1 cycles plus 1 bubble cycle.

## Configuration
- MUX_ARB_TIMEOUT_EN defined:
  - StallCnt counts consecutive BURST cycles with Ready=0 and clears on any Ready=1.
  - When StallCnt reaches TIMEOUT-1 with Ready still 0 → go to IDLE, clear Gnt and Valid, pulse TimeoutErr, set LastGnt=X, no Done.
- Not defined: StallCnt is absent, TimeoutErr is tied to 0, and a stalled burst waits indefinitely.

## Structure
- Package mux_arb_pkg holds:
  - the state encoding (ARB_IDLE, ARB_BURST)
  - requester IDs (REQ_A=1'b1, REQ_B=1'b0, matching the Selector polarity)
  - the default LEN_W and TIMEOUT constants
- Sub-module rr_pick: combinational, inputs ReqA, ReqB and LastGnt; outputs Win (requester ID) and Any.

## Test plan
- Reset mid-burst: assert Rst_n=0 during beat 2 of 4 → all registered outputs 0 immediately, with no clock edge; LastGnt=B. After release, ReqA+ReqB → GntA.
- A only, LenA=2, Ready=1: GntA=1 and Selector=1 for 3 cycles, DataOut=DataA, three BeatAckA pulses, then DoneA=1 for 1 cycle with Busy=0.
- ReqA and ReqB held, both Len=0: grant sequence A, bubble, B, bubble, A. Each Done pulses once per grant.
- Ready toggling 1,0,0,1,1 with LenB=2: BeatCnt advances only on Ready=1 edges, and DoneB follows the third accepted beat.
- ReqA dropped after beat 1 of 4, with ReqB pending: GntA=0 next cycle, no DoneA, GntB after the one-cycle bubble.
- With MUX_ARB_TIMEOUT_EN and TIMEOUT=4, Ready held 0 → after 4 stalled cycles GntA=0, TimeoutErr pulses once, no DoneA. Without the macro the grant holds for at least 100 cycles.
